// File: rtl/accel_fir_pkg.sv
// Shared widths, coefficient table and FSM encoding for the accelerometer FIR filter.
package accel_fir_pkg;

    localparam int unsigned SampleW = 16;
    localparam int unsigned CoeffW  = 8;
    localparam int unsigned AccW    = 27;
    localparam int unsigned ResW    = 30;
    localparam int unsigned MaxTaps = 16;

    // All +1: a plain moving average at TAPS = 8, OUT_SHIFT = 3.
    localparam logic [MaxTaps-1:0][CoeffW-1:0] COEFF = {MaxTaps{CoeffW'(1)}};

    typedef enum logic [1:0] {
        StIdle,
        StLatch,
        StMac,
        StDone
    } fir_state_e;

    function automatic logic signed [CoeffW-1:0] coeff_at(input logic [3:0] idx);
        return COEFF[idx];
    endfunction

endpackage

// File: rtl/accel_fir_mac.sv
// Registered signed multiply-accumulate with a combinational shifted view of the next sum.
module accel_fir_mac
    import accel_fir_pkg::*;
#(
    parameter int unsigned OUT_SHIFT = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic                      en_i,
    input  logic                      first_i,
    input  logic signed [SampleW-1:0] sample_i,
    input  logic signed [CoeffW-1:0]  coeff_i,
    output logic signed [ResW-1:0]    res_o
);

    logic signed [SampleW+CoeffW-1:0] prod;
    logic signed [AccW-1:0]           acc_q, acc_d, acc_base;

    assign prod = sample_i * coeff_i;

    always_comb begin
        acc_base = first_i ? '0 : acc_q;
        acc_d    = acc_base + AccW'(prod);
        // Shifted sum including the current product, so the last tap lands the same edge.
        res_o    = ResW'(acc_d >>> OUT_SHIFT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/accel_fir_filter.sv
// Toggle-handshake X/Y/Z FIR filter between Nios PIO ports, sharing one MAC across all taps.
module accel_fir_filter
    import accel_fir_pkg::*;
#(
    parameter int unsigned TAPS      = 8,
    parameter int unsigned OUT_SHIFT = 3
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [30:0] hardware_out_x,
    input  logic [30:0] hardware_out_y,
    input  logic [30:0] hardware_out_z,
    input  logic [3:0]  hardware_clocks,
    output logic [30:0] hardware_in_x,
    output logic [30:0] hardware_in_y,
    output logic [30:0] hardware_in_z
);

    localparam int unsigned TapW    = $clog2(TAPS);
    localparam int unsigned NumAxes = 3;

    fir_state_e                state_q, state_d;
    logic                      req_q, req_seen_q, ack_q;
    logic [1:0]                axis_q;
    logic [TapW-1:0]           tap_q;
    logic signed [SampleW-1:0] cap_q [NumAxes];
    logic signed [SampleW-1:0] dly_q [NumAxes][TAPS];
    logic signed [ResW-1:0]    res_q [NumAxes];
    logic signed [ResW-1:0]    out_q [NumAxes];

    logic                      clear, pending, last_tap, last_axis;
    logic                      capture_en, shift_en, mac_en, res_en, publish_en;
    logic                      mac_first;
    logic signed [SampleW-1:0] mac_sample;
    logic signed [CoeffW-1:0]  mac_coeff;
    logic signed [ResW-1:0]    mac_res;
    logic                      unused_bits;

    assign clear      = hardware_clocks[1];
    assign pending    = req_q != req_seen_q;
    assign last_tap   = tap_q == TapW'(TAPS - 1);
    assign last_axis  = axis_q == 2'd2;
    assign mac_first  = tap_q == '0;
    assign mac_sample = dly_q[axis_q][tap_q];
    assign mac_coeff  = coeff_at(4'(tap_q));
    assign res_en     = mac_en && last_tap;

    assign unused_bits = ^{hardware_out_x[30:16], hardware_out_y[30:16],
                           hardware_out_z[30:16], hardware_clocks[3:2]};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (pending) state_d = StLatch;
                StLatch: state_d = StMac;
                StMac:   if (last_tap && last_axis) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        capture_en = 1'b0;
        shift_en   = 1'b0;
        mac_en     = 1'b0;
        publish_en = 1'b0;
        if (!clear) begin
            unique case (state_q)
                StIdle:  capture_en = pending;
                StLatch: shift_en   = 1'b1;
                StMac:   mac_en     = 1'b1;
                StDone:  publish_en = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            req_q      <= 1'b0;
            req_seen_q <= 1'b0;
        end else begin
            req_q <= hardware_clocks[0];
            // Clear also swallows any request already pending.
            if (clear || capture_en) req_seen_q <= req_q;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ack_q  <= 1'b0;
            axis_q <= '0;
            tap_q  <= '0;
            for (int a = 0; a < NumAxes; a++) begin
                cap_q[a] <= '0;
                res_q[a] <= '0;
                out_q[a] <= '0;
                for (int t = 0; t < TAPS; t++) dly_q[a][t] <= '0;
            end
        end else if (clear) begin
            axis_q <= '0;
            tap_q  <= '0;
            for (int a = 0; a < NumAxes; a++) begin
                res_q[a] <= '0;
                out_q[a] <= '0;
                for (int t = 0; t < TAPS; t++) dly_q[a][t] <= '0;
            end
        end else begin
            if (capture_en) begin
                cap_q[0] <= hardware_out_x[SampleW-1:0];
                cap_q[1] <= hardware_out_y[SampleW-1:0];
                cap_q[2] <= hardware_out_z[SampleW-1:0];
            end
            if (shift_en) begin
                for (int a = 0; a < NumAxes; a++) begin
                    dly_q[a][0] <= cap_q[a];
                    for (int t = 1; t < TAPS; t++) dly_q[a][t] <= dly_q[a][t-1];
                end
            end
            if (mac_en) begin
                if (last_tap) begin
                    tap_q  <= '0;
                    axis_q <= last_axis ? 2'd0 : axis_q + 2'd1;
                end else begin
                    tap_q <= tap_q + TapW'(1);
                end
            end
            if (res_en) res_q[axis_q] <= mac_res;
            if (publish_en) begin
                ack_q <= ~ack_q;
                for (int a = 0; a < NumAxes; a++) out_q[a] <= res_q[a];
            end
        end
    end

    accel_fir_mac #(
        .OUT_SHIFT (OUT_SHIFT)
    ) u_mac (
        .clk_i    (clk_clk),
        .rst_ni   (reset_reset_n),
        .clr_i    (clear),
        .en_i     (mac_en),
        .first_i  (mac_first),
        .sample_i (mac_sample),
        .coeff_i  (mac_coeff),
        .res_o    (mac_res)
    );

    assign hardware_in_x = {ack_q, out_q[0]};
    assign hardware_in_y = {ack_q, out_q[1]};
    assign hardware_in_z = {ack_q, out_q[2]};

endmodule
